// File: rtl/io_in_conditioner.sv
// Pad input conditioner: per-channel synchroniser, debouncer and edge detector,
// with pending edge events arbitrated into a small valid/ready event FIFO.
module io_in_conditioner #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic [NCH-1:0]         pad_i,
  output logic [NCH-1:0]         deb_o,
  output logic [NCH-1:0]         rise_o,
  output logic [NCH-1:0]         fall_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [$clog2(NCH):0]   evt_data_o,
  output logic                   overflow_o,
  input  logic                   clr_overflow_i
);
  localparam int CW = $clog2(NCH);
  localparam int DW = CW + 1;
  localparam int KW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  logic [NCH-1:0] sync_p0 [SYNC_STAGES];
  logic [NCH-1:0] s;
  logic [KW-1:0]  cnt_p1 [NCH];
  logic [NCH-1:0] tog;
  logic [NCH-1:0] pend_p2;
  logic [NCH-1:0] pol_p2;
  logic [DW-1:0]  mem_p3 [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [NW-1:0]  count;
  logic [NW-1:0]  count_next;
  logic           pop;
  logic           can_push;
  logic           gnt_vld;
  logic [CW-1:0]  gnt_idx;
  logic [NCH-1:0] gnt_oh;
  logic           ovf_set;

  // Stage p0: synchroniser chain
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounce; a toggle needs DEB_CYCLES consecutive mismatching samples
  always_comb begin
    tog = '0;
    for (int i = 0; i < NCH; i++)
      tog[i] = (s[i] != deb_o[i]) && (cnt_p1[i] == KW'(DEB_CYCLES - 1));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      deb_o  <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < NCH; i++) cnt_p1[i] <= '0;
    end else begin
      deb_o  <= deb_o ^ tog;
      rise_o <= tog & ~deb_o;
      fall_o <= tog & deb_o;
      for (int i = 0; i < NCH; i++)
        cnt_p1[i] <= ((s[i] == deb_o[i]) || tog[i]) ? '0 : cnt_p1[i] + KW'(1);
    end
  end

  // Stage p2: pending bits and fixed-priority arbiter (lowest index wins)
  always_comb begin
    pop      = evt_valid_o & evt_ready_i;
    can_push = (count < NW'(FIFO_DEPTH)) | pop;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_p2[i]) begin
        gnt_vld = can_push;
        gnt_idx = CW'(i);
      end
    end
    gnt_oh     = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    ovf_set    = |(tog & pend_p2 & ~gnt_oh);
    count_next = count + NW'(gnt_vld) - NW'(pop);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      pend_p2    <= '0;
      pol_p2     <= '0;
      overflow_o <= 1'b0;
    end else begin
      // An edge landing in its own grant cycle simply re-arms the channel.
      pend_p2    <= (pend_p2 & ~gnt_oh) | tog;
      pol_p2     <= (pol_p2 & ~tog) | (tog & ~deb_o);
      overflow_o <= ovf_set | (overflow_o & ~clr_overflow_i);
    end
  end

  // Stage p3: event FIFO
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_p3[k] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      evt_valid_o <= 1'b0;
    end else begin
      if (gnt_vld) begin
        mem_p3[wr_ptr] <= {pol_p2[gnt_idx], gnt_idx};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      evt_valid_o <= (count_next != '0);
    end
  end

  assign evt_data_o = mem_p3[rd_ptr];

endmodule
